i2c_init_seq: RTL and testbench



---
 rtl/i2c_init_seq.sv | 272 +++++++++++++++++++++++++++
 tb/tb_i2c_init_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_init_seq.sv
// Register-initialisation sequencer: walks a ROM table and drives the I2C byte controller.
// Build option: define I2C_INIT_VERIFY_EN to perform READ_CHECK reads and compare the result.
module i2c_init_seq #(
  parameter int unsigned CLK_DIV   = 64,
  parameter int unsigned TBL_AW    = 6,
  parameter logic [6:0]  DEV_ADDR  = 7'h50,
  parameter int unsigned WR_LEN    = 3,
  parameter int unsigned RD_LEN    = 2,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [TBL_AW-1:0] err_idx,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [23:0]       tbl_data,
  output logic              i2c_strobe,
  output logic              i2c_enable,
  output logic [6:0]        i2c_addr,
  output logic              reg_rdwr,
  output logic [7:0]        reg_addr,
  output logic [4:0]        reg_len,
  output logic [7:0]        reg_wrdata,
  input  logic [7:0]        reg_rddata,
  input  logic              reg_done,
  input  logic              i2c_ack
);

  localparam logic [15:0] CntLast = 16'(CLK_DIV - 1);
  localparam int unsigned RetryW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RetryW-1:0] MaxRetry = RetryW'(MAX_RETRY);

  typedef enum logic [3:0] {
    StIdle, StFetch, StDecode, StIssue, StWait, StCheck, StDelay, StDone, StErr
  } state_e;

  typedef enum logic [1:0] {OpWrite, OpRead, OpDelay, OpEnd} op_e;

  // Strobe generator: free-running, independent of the sequencer
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q <= '0;
    end else if (cnt_q == CntLast) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign i2c_strobe = (cnt_q == CntLast);

  state_e            state_q, state_d;
  logic [TBL_AW-1:0] idx_q, idx_d;
  logic [15:0]       field_q, field_d;
  logic              rdwr_q, rdwr_d;
  logic [4:0]        len_q, len_d;
  logic              en_q, en_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [15:0]       dly_q, dly_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [TBL_AW-1:0] err_idx_q, err_idx_d;
  logic              ack_q, ack_d;
  logic              advance;
  op_e               tbl_op;

  assign tbl_op = op_e'(tbl_data[23:22]);

`ifdef I2C_INIT_VERIFY_EN
  op_e        op_q, op_d;
  logic [7:0] rd_q, rd_d;
  logic       unused_tbl;

  assign unused_tbl = ^tbl_data[21:16];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      op_q <= OpWrite;
      rd_q <= '0;
    end else begin
      op_q <= op_d;
      rd_q <= rd_d;
    end
  end
`else
  logic unused_tbl;

  assign unused_tbl = ^{tbl_data[21:16], reg_rddata};
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      field_q   <= '0;
      rdwr_q    <= 1'b0;
      len_q     <= '0;
      en_q      <= 1'b0;
      retry_q   <= '0;
      dly_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      field_q   <= field_d;
      rdwr_q    <= rdwr_d;
      len_q     <= len_d;
      en_q      <= en_d;
      retry_q   <= retry_d;
      dly_q     <= dly_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      ack_q     <= ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    field_d   = field_q;
    rdwr_d    = rdwr_q;
    len_d     = len_q;
    en_d      = en_q;
    retry_d   = retry_q;
    dly_d     = dly_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    ack_d     = ack_q;
    advance   = 1'b0;
`ifdef I2C_INIT_VERIFY_EN
    op_d      = op_q;
    rd_d      = rd_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (go) begin
          done_d    = 1'b0;
          err_d     = 1'b0;
          err_idx_d = '0;
          idx_d     = '0;
          retry_d   = '0;
          busy_d    = 1'b1;
          state_d   = StFetch;
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        field_d = tbl_data[15:0];
        retry_d = '0;
`ifdef I2C_INIT_VERIFY_EN
        op_d    = tbl_op;
`endif
        unique case (tbl_op)
          OpWrite: begin
            rdwr_d  = 1'b0;
            len_d   = 5'(WR_LEN);
            state_d = StIssue;
          end
          OpRead: begin
`ifdef I2C_INIT_VERIFY_EN
            rdwr_d  = 1'b1;
            len_d   = 5'(RD_LEN);
            state_d = StIssue;
`else
            advance = 1'b1;
`endif
          end
          OpDelay: begin
            dly_d   = tbl_data[15:0];
            state_d = StDelay;
          end
          OpEnd: state_d = StDone;
        endcase
      end
      StIssue: begin
        en_d    = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        // Response is captured here; reg_done/ack may change before CHECK acts
        if (reg_done) begin
          en_d    = 1'b0;
          ack_d   = i2c_ack;
`ifdef I2C_INIT_VERIFY_EN
          rd_d    = reg_rddata;
`endif
          state_d = StCheck;
        end
      end
      StCheck: begin
        // Hold off until the controller has released reg_done
        if (!reg_done) begin
          if (ack_q) begin
            if (retry_q < MaxRetry) begin
              retry_d = retry_q + RetryW'(1);
              state_d = StIssue;
            end else begin
              err_idx_d = idx_q;
              state_d   = StErr;
            end
          end
`ifdef I2C_INIT_VERIFY_EN
          else if (op_q == OpRead && rd_q != field_q[7:0]) begin
            err_idx_d = idx_q;
            state_d   = StErr;
          end
`endif
          else begin
            advance = 1'b1;
          end
        end
      end
      StDelay: begin
        if (dly_q == '0) begin
          advance = 1'b1;
        end else if (i2c_strobe) begin
          dly_d = dly_q - 16'd1;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      StErr: begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Running off the end of the table without END is an error
    if (advance) begin
      if (idx_q == '1) begin
        err_idx_d = '1;
        state_d   = StErr;
      end else begin
        idx_d   = idx_q + TBL_AW'(1);
        state_d = StFetch;
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_idx    = err_idx_q;
  assign tbl_addr   = idx_q;
  assign i2c_enable = en_q;
  assign i2c_addr   = DEV_ADDR;
  assign reg_rdwr   = rdwr_q;
  assign reg_addr   = field_q[15:8];
  assign reg_len    = len_q;
  assign reg_wrdata = field_q[7:0];

endmodule

// File: tb/tb_i2c_init_seq.sv
// Bench for i2c_init_seq: ROM + controller models, vector table and transfer scoreboard.
module tb_i2c_init_seq;

  localparam int unsigned ClkDiv   = 8;
  localparam int unsigned MaxRetry = 3;
`ifdef I2C_INIT_VERIFY_EN
  localparam bit Verify = 1'b1;
`else
  localparam bit Verify = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arst_n = 1'b1;
  logic        go = 1'b0;
  logic        busy, done, err;
  logic [5:0]  err_idx, tbl_addr;
  logic [23:0] tbl_data;
  logic        i2c_strobe, i2c_enable;
  logic [6:0]  i2c_addr;
  logic        reg_rdwr;
  logic [7:0]  reg_addr;
  logic [4:0]  reg_len;
  logic [7:0]  reg_wrdata;
  logic [7:0]  reg_rddata;
  logic        reg_done;
  logic        i2c_ack;

  i2c_init_seq #(
    .CLK_DIV  (ClkDiv),
    .TBL_AW   (6),
    .DEV_ADDR (7'h50),
    .WR_LEN   (3),
    .RD_LEN   (2),
    .MAX_RETRY(MaxRetry)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .go        (go),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_idx   (err_idx),
    .tbl_addr  (tbl_addr),
    .tbl_data  (tbl_data),
    .i2c_strobe(i2c_strobe),
    .i2c_enable(i2c_enable),
    .i2c_addr  (i2c_addr),
    .reg_rdwr  (reg_rdwr),
    .reg_addr  (reg_addr),
    .reg_len   (reg_len),
    .reg_wrdata(reg_wrdata),
    .reg_rddata(reg_rddata),
    .reg_done  (reg_done),
    .i2c_ack   (i2c_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] addr;
    logic       rdwr;
    logic [7:0] ra;
    logic [7:0] wd;
    logic [4:0] len;
  } xfer_t;

  typedef struct {
    logic [23:0] e0, e1, e2, fill;
    logic        nack;
    logic [7:0]  rdval;
    bit          go_mid;
    logic        exp_done, exp_err;
    logic [5:0]  exp_idx;
    int          exp_max;
    int          min_strobes;
  } vec_t;

  logic [23:0] rom [64];
  logic        nack_mode = 1'b0;
  logic [7:0]  rd_val = 8'h00;
  xfer_t       got_q[$];
  xfer_t       exp_q[$];
  int          proto_err = 0;
  logic        ctl_act;
  int          ctl_ticks;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Synchronous table ROM
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  // Controller model: answers two strobes after enable, holds reg_done to the next strobe
  always @(negedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ctl_act    <= 1'b0;
      ctl_ticks  <= 0;
      reg_done   <= 1'b0;
      i2c_ack    <= 1'b0;
      reg_rddata <= 8'h00;
    end else begin
      if (ctl_act && !i2c_enable) proto_err++;
      if (reg_done && i2c_strobe && i2c_enable) proto_err++;
      if (reg_done) begin
        if (i2c_strobe) reg_done <= 1'b0;
      end else if (ctl_act) begin
        if (i2c_strobe) begin
          if (ctl_ticks == 1) begin
            reg_done   <= 1'b1;
            i2c_ack    <= nack_mode;
            reg_rddata <= rd_val;
            ctl_act    <= 1'b0;
          end
          ctl_ticks <= ctl_ticks + 1;
        end
      end else if (i2c_enable) begin
        ctl_act   <= 1'b1;
        ctl_ticks <= 0;
        got_q.push_back({i2c_addr, reg_rdwr, reg_addr, reg_wrdata, reg_len});
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected transfers from the table contents and controller behaviour
  task automatic build_expect();
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      logic [23:0] w;
      int reps;
      w = rom[i];
      if (w[23:22] == 2'b11) break;
      if (w[23:22] == 2'b10) continue;
      if (w[23:22] == 2'b01 && !Verify) continue;
      reps = nack_mode ? MaxRetry + 1 : 1;
      for (int r = 0; r < reps; r++) begin
        exp_q.push_back({7'h50, (w[23:22] == 2'b01), w[15:8], w[7:0],
                         (w[23:22] == 2'b01) ? 5'd2 : 5'd3});
      end
      if (nack_mode) break;
      if (w[23:22] == 2'b01 && rd_val != w[7:0]) break;
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int max_addr;
    int strobes;
    bit finished;
    for (int i = 0; i < 64; i++) rom[i] = v.fill;
    rom[0] = v.e0;
    rom[1] = v.e1;
    rom[2] = v.e2;
    nack_mode = v.nack;
    rd_val    = v.rdval;
    build_expect();
    got_q.delete();
    proto_err = 0;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk({name, ".start"}, {61'd0, busy, done, err}, 64'b100);
    max_addr = 0;
    strobes  = 0;
    finished = 1'b0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      go = (v.go_mid && cyc == 40);
      @(negedge clk);
      if (i2c_strobe) strobes++;
      if (int'(tbl_addr) > max_addr) max_addr = int'(tbl_addr);
      if (done || err) begin
        finished = 1'b1;
        break;
      end
    end
    go = 1'b0;
    if (!finished) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.timeout: got busy=%0b expected done or err", name, busy);
    end
    chk({name, ".status"}, {55'd0, busy, done, err, err_idx},
        {55'd0, 1'b0, v.exp_done, v.exp_err, v.exp_idx});
    chk({name, ".xfers"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      xfer_t g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({name, ".xfer"}, 64'(g), 64'(e));
    end
    chk({name, ".max_addr"}, 64'(max_addr), 64'(v.exp_max));
    chk({name, ".strobes_ok"}, 64'(strobes >= v.min_strobes), 64'd1);
    chk({name, ".protocol"}, 64'(proto_err), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{24'h0010A5, 24'hC00000, 24'hC00000, 24'hC00000, 1'b0, 8'h00, 1'b0,
                1'b1, 1'b0, 6'd0, 1, 0};
    vecs[1] = '{24'h003301, 24'hC00000, 24'hC00000, 24'hC00000, 1'b1, 8'h00, 1'b0,
                1'b0, 1'b1, 6'd0, 0, 0};
    vecs[2] = '{24'h800005, 24'hC00000, 24'hC00000, 24'hC00000, 1'b0, 8'h00, 1'b0,
                1'b1, 1'b0, 6'd0, 1, 5};
    vecs[3] = '{24'h40203C, 24'hC00000, 24'hC00000, 24'hC00000, 1'b0, 8'h3C, 1'b0,
                1'b1, 1'b0, 6'd0, 1, 0};
    vecs[4] = '{24'h40203C, 24'hC00000, 24'hC00000, 24'hC00000, 1'b0, 8'h3D, 1'b0,
                !Verify, Verify, 6'd0, Verify ? 0 : 1, 0};
    vecs[5] = '{24'h000102, 24'h000304, 24'hC00000, 24'hC00000, 1'b0, 8'h00, 1'b1,
                1'b1, 1'b0, 6'd0, 2, 0};
    vecs[6] = '{24'h800000, 24'h007FFF, 24'hC00000, 24'hC00000, 1'b0, 8'h00, 1'b0,
                1'b1, 1'b0, 6'd0, 2, 0};
    vecs[7] = '{24'h0055AA, 24'h0055AA, 24'h0055AA, 24'h0055AA, 1'b0, 8'h00, 1'b0,
                1'b0, 1'b1, 6'h3F, 63, 0};
    for (int i = 0; i < 64; i++) rom[i] = 24'hC00000;

    #1 arst_n = 1'b0;
    #20;
    chk("reset_state",
        {27'd0, busy, done, err, err_idx, tbl_addr, i2c_strobe, i2c_enable, reg_rdwr,
         reg_addr, reg_len, reg_wrdata},
        64'd0);
    chk("reset_i2c_addr", 64'(i2c_addr), 64'h50);

    // Strobe timing: cycle 0 is the interval right after reset release
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    chk("strobe_c0", 64'(i2c_strobe), 64'd0);
    for (int c = 1; c < 24; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("strobe_c%0d", c), 64'(i2c_strobe), 64'((c % ClkDiv) == ClkDiv - 1));
    end

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Reset in the middle of a handshake
    for (int i = 0; i < 64; i++) rom[i] = 24'hC00000;
    rom[0] = 24'h001122;
    nack_mode = 1'b0;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int c = 0; c < 200 && !ctl_act; c++) @(negedge clk);
    chk("midreset.in_wait", {62'd0, ctl_act, i2c_enable}, 64'b11);
    #1 arst_n = 1'b0;
    #1;
    chk("midreset.outputs", {60'd0, i2c_enable, busy, done, err}, 64'd0);
    chk("midreset.tbl_addr", 64'(tbl_addr), 64'd0);
    @(negedge clk);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_vec("after_reset", vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
